// File: rtl/demux64_12_reg.sv
// rtl/demux64_12_reg.sv - registered 1-to-2 stream demux with per-channel holding registers
// Optional transfer counters cnt0/cnt1 are built only when DEMUX_CNT_EN is defined.
module demux64_12_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DEMUX_CNT_EN
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
`endif
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  input  logic             S,
  output logic             i_ready,
  output logic [WIDTH-1:0] o0,
  output logic             o0_valid,
  input  logic             o0_ready,
  output logic [WIDTH-1:0] o1,
  output logic             o1_valid,
  input  logic             o1_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t st0_q, st0_d;
  state_t st1_q, st1_d;

  logic cap0, cap1;
  logic accept;
  logic load0, load1;
  logic drain0, drain1;

  assign o0_valid = (st0_q == FULL);
  assign o1_valid = (st1_q == FULL);

  // A channel can take a word if it is empty or its current word leaves this cycle.
  assign cap0    = !o0_valid || o0_ready;
  assign cap1    = !o1_valid || o1_ready;
  assign i_ready = S ? cap1 : cap0;

  assign accept = i_valid && i_ready;
  assign load0  = accept && !S;
  assign load1  = accept && S;
  assign drain0 = o0_valid && o0_ready;
  assign drain1 = o1_valid && o1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      st0_q <= EMPTY;
      st1_q <= EMPTY;
    end else begin
      st0_q <= st0_d;
      st1_q <= st1_d;
    end
  end

  always_comb begin
    st0_d = st0_q;
    case (st0_q)
      EMPTY:   if (load0) st0_d = FULL;
      FULL:    if (drain0 && !load0) st0_d = EMPTY;
      default: st0_d = EMPTY;
    endcase
  end

  always_comb begin
    st1_d = st1_q;
    case (st1_q)
      EMPTY:   if (load1) st1_d = FULL;
      FULL:    if (drain1 && !load1) st1_d = EMPTY;
      default: st1_d = EMPTY;
    endcase
  end

  // Data registers only change on load, so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      o0 <= '0;
      o1 <= '0;
    end else begin
      if (load0) o0 <= i;
      if (load1) o1 <= i;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + CNT_W'(1);
      if (drain1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule
